// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD controller and its counter.
package gcd_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CMP    = 3'd3,
    SUB    = 3'd4,
    WB     = 3'd5,
    FIN    = 3'd6
  } state_t;

endpackage

// File: rtl/gcd_controller_iter_counter.sv
// Iteration counter: clear, saturating increment and terminal-count compare.
module iter_counter
  import gcd_pkg::*;
#(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ITER_W-1:0] cnt,
  output logic              at_max
);

  localparam logic [ITER_W-1:0] SAT_VAL = '1;
  localparam logic [ITER_W-1:0] MAX_VAL = ITER_W'(MAX_ITER);

  logic [ITER_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != SAT_VAL)) begin
      cnt_reg <= cnt_reg + ITER_W'(1);
    end
  end

  assign cnt    = cnt_reg;
  assign at_max = (cnt_reg == MAX_VAL);

endmodule

// File: rtl/gcd_controller.sv
// Sequencer for the subtractive GCD datapath: operand load handshake,
// compare/subtract/write-back iterations, done or timeout reporting.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              eqz,
  output logic              enA,
  output logic              enB,
  output logic              enA_c,
  output logic              enB_c,
  output logic              com_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t state_reg, state_next;
  logic   done_reg, done_next;
  logic   err_reg, err_next;
  logic   cnt_clr, cnt_inc, cnt_at_max;

  iter_counter #(
    .ITER_W  (ITER_W),
    .MAX_ITER(MAX_ITER)
  ) u_iter_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (iter_cnt),
    .at_max(cnt_at_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    in_ready   = 1'b0;
    enA        = 1'b0;
    enB        = 1'b0;
    enA_c      = 1'b0;
    enB_c      = 1'b0;
    com_en     = 1'b0;
    busy       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          done_next  = 1'b0;
          err_next   = 1'b0;
          cnt_clr    = 1'b1;
          state_next = LOAD_A;
        end
      end
      LOAD_A: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        enA      = in_valid;
        if (in_valid) state_next = LOAD_B;
      end
      LOAD_B: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        enB      = in_valid;
        if (in_valid) state_next = CMP;
      end
      CMP: begin
        busy   = 1'b1;
        com_en = 1'b1;
        // Equality wins over timeout when both hold on the same compare.
        if (eqz) begin
          done_next  = 1'b1;
          state_next = FIN;
        end else if (cnt_at_max) begin
          err_next   = 1'b1;
          state_next = FIN;
        end else begin
          state_next = SUB;
        end
      end
      SUB: begin
        busy       = 1'b1;
        com_en     = 1'b1;
        state_next = WB;
      end
      WB: begin
        busy       = 1'b1;
        com_en     = 1'b1;
        enA_c      = 1'b1;
        enB_c      = 1'b1;
        cnt_inc    = 1'b1;
        state_next = CMP;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign done = done_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_gcd_controller.sv
// Randomized bench for gcd_controller with a behavioural datapath and a
// timeline model of the expected outputs for each operation.
module tb_gcd_controller;
  import gcd_pkg::*;

  localparam int ITER_W   = 8;
  localparam int MAX_ITER = 5;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_ready, eqz;
  logic              enA, enB, enA_c, enB_c, com_en, busy, done, err;
  logic [ITER_W-1:0] iter_cnt;
  logic [DATA_W-1:0] data_in, dp_a, dp_b, d_ab, d_ba;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gcd_controller #(
    .ITER_W  (ITER_W),
    .MAX_ITER(MAX_ITER)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .eqz     (eqz),
    .enA     (enA),
    .enB     (enB),
    .enA_c   (enA_c),
    .enB_c   (enB_c),
    .com_en  (com_en),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .iter_cnt(iter_cnt)
  );

  // Behavioural datapath: operand registers, registered differences.
  assign eqz = (dp_a == dp_b);
  always @(posedge clk) begin
    if (com_en) begin
      d_ab <= dp_a - dp_b;
      d_ba <= dp_b - dp_a;
    end
    if (enA) dp_a <= data_in;
    else if (enA_c && dp_a > dp_b) dp_a <= d_ab;
    if (enB) dp_b <= data_in;
    else if (enB_c && dp_b > dp_a) dp_b <= d_ba;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void gcd_model(input int a, input int b, output int n,
                                    output int res, output bit er);
    n = 0;
    while (a != b && n < MAX_ITER) begin
      if (a > b) a -= b;
      else b -= a;
      n++;
    end
    er  = (a != b);
    res = a;
  endfunction

  // Expected-operation context shared with the compare process.
  bit track_en = 1'b0;
  int k, e_sa, e_sb, e_n, e_res;
  bit e_err;
  int done_k, wb_cnt;

  always @(negedge clk) begin
    if (track_en) begin : cmp_blk
      int la, lb, base, fin, it;
      bit x_busy, x_rdy, x_ena, x_enb, x_enac, x_com, x_done, x_err;
      la   = 1 + e_sa;
      lb   = la + 1 + e_sb;
      base = lb + 1;
      fin  = base + 3 * e_n + 1;
      {x_busy, x_rdy, x_ena, x_enb, x_enac, x_com, x_done, x_err} = '0;
      it = (k < base) ? 0 : ((k - base) / 3);
      if (it > e_n) it = e_n;
      if (k <= la) begin
        x_busy = 1; x_rdy = 1; x_ena = (k == la);
      end else if (k <= lb) begin
        x_busy = 1; x_rdy = 1; x_enb = (k == lb);
      end else if (k < fin) begin
        x_busy = 1; x_com = 1; x_enac = ((k - base) % 3 == 2);
      end else begin
        x_done = !e_err; x_err = e_err;
      end
      chk($sformatf("busy@k%0d", k),     busy,     x_busy);
      chk($sformatf("in_ready@k%0d", k), in_ready, x_rdy);
      chk($sformatf("enA@k%0d", k),      enA,      x_ena);
      chk($sformatf("enB@k%0d", k),      enB,      x_enb);
      chk($sformatf("enA_c@k%0d", k),    enA_c,    x_enac);
      chk($sformatf("enB_c@k%0d", k),    enB_c,    x_enac);
      chk($sformatf("com_en@k%0d", k),   com_en,   x_com);
      chk($sformatf("done@k%0d", k),     done,     x_done);
      chk($sformatf("err@k%0d", k),      err,      x_err);
      chk($sformatf("iter_cnt@k%0d", k), iter_cnt, it);
      if (k == fin && !e_err) chk($sformatf("data_out@k%0d", k), dp_a, e_res);
      if (done === 1'b1 && done_k < 0) done_k = k;
      if (enA_c === 1'b1) wb_cnt++;
      k++;
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_enables"},  {enA, enB, enA_c, enB_c, com_en}, 0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_err"},      err,      0);
    chk({tag, "_iter_cnt"}, iter_cnt, 0);
  endtask

  task automatic run_op(input int a, input int b, input int sa, input int sb,
                        input bit noisy, input int abort_k);
    int n, res, fin;
    bit er, aborted;
    gcd_model(a, b, n, res, er);
    fin     = 3 + sa + sb + 3 * n + 1;
    aborted = 1'b0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    e_sa = sa; e_sb = sb; e_n = n; e_res = res; e_err = er;
    k = 1; done_k = -1; wb_cnt = 0; track_en = 1'b1;
    for (int c = 1; c <= fin + 2 && !aborted; c++) begin
      in_valid = 1'b0; start = 1'b0; data_in = DATA_W'($urandom);
      if (c == 1 + sa) begin
        in_valid = 1'b1; data_in = DATA_W'(a);
      end else if (c == 2 + sa + sb) begin
        in_valid = 1'b1; data_in = DATA_W'(b);
      end else if (noisy && c > 2 + sa + sb) begin
        in_valid = 1'($urandom);
        if (c <= fin) start = 1'($urandom);
      end
      if (abort_k != 0 && c == abort_k) rst = 1'b1;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0; track_en = 1'b0; aborted = 1'b1;
        @(negedge clk);
        chk_reset_state("mid_reset");
      end
    end
    track_en = 1'b0; start = 1'b0; in_valid = 1'b0;
    $display("op a=%0d b=%0d stall=%0d/%0d noisy=%0d abort=%0d -> n=%0d err=%0d res=%0d done_k=%0d",
             a, b, sa, sb, noisy, abort_k, n, er, res, done_k);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    run_op(12, 8, 0, 0, 1'b0, 0);
    chk("12_8_done_latency", done_k, 10);
    chk("12_8_iter_cnt", iter_cnt, 2);
    chk("12_8_data_out", dp_a, 4);
    chk("12_8_err", err, 0);

    run_op(7, 7, 0, 0, 1'b0, 0);
    chk("7_7_done_latency", done_k, 4);
    chk("7_7_iter_cnt", iter_cnt, 0);
    chk("7_7_data_out", dp_a, 7);
    chk("7_7_wb_pulses", wb_cnt, 0);

    run_op(9, 0, 0, 0, 1'b0, 0);
    chk("9_0_err", err, 1);
    chk("9_0_done", done, 0);
    chk("9_0_iter_cnt", iter_cnt, 5);
    chk("9_0_wb_pulses", wb_cnt, 5);
    chk("9_0_never_done", done_k, -1);

    run_op(0, 0, 0, 0, 1'b0, 0);
    chk("0_0_data_out", dp_a, 0);
    chk("0_0_done", done, 1);

    run_op(15, 10, 3, 2, 1'b0, 0);
    chk("15_10_stall_latency", done_k, 15);
    chk("15_10_data_out", dp_a, 5);
    chk("15_10_iter_cnt", iter_cnt, 2);

    run_op(200, 3, 0, 0, 1'b0, 4);
    run_op(6, 4, 0, 0, 1'b0, 0);
    chk("6_4_data_out", dp_a, 2);
    chk("6_4_done", done, 1);

    run_op(18, 12, 1, 1, 1'b1, 0);
    chk("18_12_noisy_data_out", dp_a, 6);

    for (int i = 0; i < 25; i++) begin
      run_op(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
